// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiply/divide unit op codes, its FSM states, and
// the R-type funct codes for the HI/LO instructions, which the core decoder also uses.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } t_md_op;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DIV   = 2'd2,
    ST_FIXUP = 2'd3
  } t_md_state;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// Core <-> multiply/divide unit connection.
// master (core): start, op, op_a, op_b, read_req out; hi, lo, busy, stall, done in.
// slave (unit): the same signals in the opposite direction.
interface mips_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             read_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;

  modport master (
    output start, op, op_a, op_b, read_req,
    input  hi, lo, busy, stall, done
  );

  modport slave (
    input  start, op, op_a, op_b, read_req,
    output hi, lo, busy, stall, done
  );
endinterface

// File: rtl/mips_div_step.sv
// One restoring-division step, purely combinational.
// Inputs:  partial_rem (current remainder, always < divisor), divisor, next_bit (next dividend bit).
// Outputs: new_rem_c (updated remainder), q_bit_c (quotient bit).
module mips_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] partial_rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             next_bit,
  output logic [WIDTH-1:0] new_rem_c,
  output logic             q_bit_c
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  assign shifted = {partial_rem, next_bit};
  // Because partial_rem < divisor, a successful subtraction always fits in WIDTH bits.
  assign diff      = shifted[WIDTH-1:0] - divisor;
  assign q_bit_c   = (shifted >= {1'b0, divisor});
  assign new_rem_c = q_bit_c ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit that owns HI/LO.
// Ports: clk, reset (sync, active-low), clock_enable (freezes all state when low),
//        bus (slave): start/op/op_a/op_b/read_req in; hi/lo/busy/done registered out,
//        stall = busy & (start | read_req), combinational.
// WIDTH must be even and >= 8; MUL_STEP_BITS is 1, 2 or 4 and must divide WIDTH.
module mips_muldiv_unit #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned MUL_STEP_BITS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clock_enable,
  mips_muldiv_unit_if.slave  bus
);
  import mips_pkg::*;

  localparam int unsigned DW         = 2 * WIDTH;
  localparam int unsigned MUL_CYCLES = WIDTH / MUL_STEP_BITS;
  localparam int unsigned CNT_W      = $clog2(WIDTH + 1);

  t_md_state        state_q, next_state;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [DW-1:0]    acc_q, mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] rem_q, divisor_q, dq_q;
  logic             is_div_q, res_neg_q, rem_neg_q;

  logic             accept_mul, accept_div, wr_hi, wr_lo, step, finish;
  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [DW-1:0]    mul_pp, prod_fix;
  logic [WIDTH-1:0] rem_nxt, quo_fix, rem_fix;
  logic             q_bit;

  // Operand magnitudes for signed ops; the most negative value maps to its unsigned magnitude.
  assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign a_neg     = is_signed & bus.op_a[WIDTH-1];
  assign b_neg     = is_signed & bus.op_b[WIDTH-1];
  assign a_mag     = a_neg ? -bus.op_a : bus.op_a;
  assign b_mag     = b_neg ? -bus.op_b : bus.op_b;

  // Partial product for the MUL_STEP_BITS multiplier bits retired this cycle.
  always_comb begin
    mul_pp = '0;
    for (int unsigned i = 0; i < MUL_STEP_BITS; i++) begin
      if (mplier_q[i]) mul_pp = mul_pp + (mcand_q << i);
    end
  end

  mips_div_step #(.WIDTH(WIDTH)) u_div_step (
    .partial_rem (rem_q),
    .divisor     (divisor_q),
    .next_bit    (dq_q[WIDTH-1]),
    .new_rem_c   (rem_nxt),
    .q_bit_c     (q_bit)
  );

  // Sign correction applied in FIXUP.
  assign prod_fix = res_neg_q ? -acc_q : acc_q;
  assign quo_fix  = res_neg_q ? -dq_q  : dq_q;
  assign rem_fix  = rem_neg_q ? -rem_q : rem_q;

  // Next state and per-cycle control strobes.
  always_comb begin
    next_state = state_q;
    accept_mul = 1'b0;
    accept_div = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    if (clock_enable) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                accept_mul = 1'b1;
                next_state = ST_MUL;
              end
              OP_DIV, OP_DIVU: begin
                accept_div = 1'b1;
                next_state = ST_DIV;
              end
              OP_MTHI: wr_hi = 1'b1;
              OP_MTLO: wr_lo = 1'b1;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          step = 1'b1;
          if (cnt_q == CNT_W'(1)) next_state = ST_FIXUP;
        end
        ST_FIXUP: begin
          finish     = 1'b1;
          next_state = ST_IDLE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Control state, iteration counter and the architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= next_state;
      busy_q  <= (next_state != ST_IDLE);
      done_q  <= finish;
      if (accept_mul)      cnt_q <= CNT_W'(MUL_CYCLES);
      else if (accept_div) cnt_q <= CNT_W'(WIDTH);
      else if (step)       cnt_q <= cnt_q - CNT_W'(1);
      if (wr_hi) hi_q <= bus.op_a;
      if (wr_lo) lo_q <= bus.op_a;
      if (finish) begin
        if (is_div_q) begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end else begin
          {hi_q, lo_q} <= prod_fix;
        end
      end
    end
  end

  // Iteration datapath; only loaded on accept and advanced on enabled steps.
  always_ff @(posedge clk) begin
    if (accept_mul) begin
      acc_q     <= '0;
      mcand_q   <= DW'(a_mag);
      mplier_q  <= b_mag;
      res_neg_q <= a_neg ^ b_neg;
      rem_neg_q <= 1'b0;
      is_div_q  <= 1'b0;
    end
    if (accept_div) begin
      rem_q     <= '0;
      divisor_q <= b_mag;
      dq_q      <= a_mag;
      res_neg_q <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
      is_div_q  <= 1'b1;
    end
    if (step && state_q == ST_MUL) begin
      acc_q    <= acc_q + mul_pp;
      mcand_q  <= mcand_q << MUL_STEP_BITS;
      mplier_q <= mplier_q >> MUL_STEP_BITS;
    end
    // Dividend bits shift out the top of dq_q while quotient bits shift in at the bottom.
    if (step && state_q == ST_DIV) begin
      rem_q <= rem_nxt;
      dq_q  <= {dq_q[WIDTH-2:0], q_bit};
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.stall = busy_q & (bus.start | bus.read_req);

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench: two units (1 and 4 multiplier bits per cycle) share one stimulus
// stream; each is checked cycle by cycle against an arithmetic HI/LO reference model.
module tb_mips_muldiv_unit;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, ce, start, read_req;
  logic [2:0]   op;
  logic [W-1:0] op_a, op_b;

  int           n_vec  = 0;
  int           n_fail = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  always #5 clk = ~clk;

  mips_muldiv_unit_if #(.WIDTH(W)) bus1 ();
  mips_muldiv_unit_if #(.WIDTH(W)) bus4 ();

  assign bus1.start = start;  assign bus1.op = op;  assign bus1.op_a = op_a;
  assign bus1.op_b = op_b;    assign bus1.read_req = read_req;
  assign bus4.start = start;  assign bus4.op = op;  assign bus4.op_a = op_a;
  assign bus4.op_b = op_b;    assign bus4.read_req = read_req;

  mips_muldiv_unit #(.WIDTH(W), .MUL_STEP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .clock_enable(ce), .bus(bus1));
  mips_muldiv_unit #(.WIDTH(W), .MUL_STEP_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .clock_enable(ce), .bus(bus4));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {hi, lo} the architecture defines for op on a, b.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [W-1:0] a, b);
    logic [63:0] r;
    int          sa, sb;
    longint      p;
    sa = a;
    sb = b;
    case (o)
      3'd0: begin p = longint'(sa) * longint'(sb); r = 64'(p); end
      3'd1: r = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0)                                      r = {a, a[W-1] ? 32'd1 : 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else                                             r = {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else        r = {a % b, a / b};
      end
      default: r = {m_hi, m_lo};
    endcase
    return r;
  endfunction

  task automatic observe(input string nm, input int cyc, input int lexp,
                         input logic b, d, s, input logic [W-1:0] h, l,
                         input logic [W-1:0] oh, ol, nh, nl);
    logic eb;
    eb = (cyc <= lexp);
    check($sformatf("%s c%0d busy", nm, cyc), 64'(b), 64'(eb));
    check($sformatf("%s c%0d done", nm, cyc), 64'(d), 64'(cyc == lexp + 1));
    check($sformatf("%s c%0d stall", nm, cyc), 64'(s), 64'(eb & (start | read_req)));
    check($sformatf("%s c%0d hi", nm, cyc), 64'(h), 64'(eb ? oh : nh));
    check($sformatf("%s c%0d lo", nm, cyc), 64'(l), 64'(eb ? ol : nl));
  endtask

  // Multi-cycle op; optional held read_req, an ignored start mid-op, and a 5-cycle freeze.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, b,
                        input bit rr, input bit poke, input int fz);
    logic [63:0]  exp;
    logic [W-1:0] oh, ol;
    int           lexp1, lexp4, maxl;
    bit           is_mul;
    exp    = model(o, a, b);
    oh     = m_hi;
    ol     = m_lo;
    is_mul = (o <= 3'd1);
    lexp1  = (is_mul ? W : W) + 1;
    lexp4  = (is_mul ? W / 4 : W) + 1;
    if (fz >= 0) begin lexp1 += 5; lexp4 += 5; end
    maxl = (lexp1 > lexp4) ? lexp1 : lexp4;
    @(negedge clk);
    start = 1'b1; op = o; op_a = a; op_b = b; read_req = rr;
    #1;
    check("idle start stall s1", 64'(bus1.stall), 64'(0));
    check("idle start stall s4", 64'(bus4.stall), 64'(0));
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= maxl + 2; cyc++) begin
      if (cyc > 1) @(negedge clk);
      ce    = !(fz >= 0 && cyc >= fz && cyc < fz + 5);
      start = poke && (cyc == 2);
      if (start) begin op = 3'd4; op_a = $urandom; end
      #1;
      observe("s1", cyc, lexp1, bus1.busy, bus1.done, bus1.stall, bus1.hi, bus1.lo,
              oh, ol, exp[63:32], exp[31:0]);
      observe("s4", cyc, lexp4, bus4.busy, bus4.done, bus4.stall, bus4.hi, bus4.lo,
              oh, ol, exp[63:32], exp[31:0]);
    end
    start = 1'b0; read_req = 1'b0; ce = 1'b1;
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  // Single-cycle or ignored op issued in IDLE.
  task automatic simple_op(input logic [2:0] o, input logic [W-1:0] a, b);
    @(negedge clk);
    start = 1'b1; op = o; op_a = a; op_b = b; read_req = 1'b1;
    #1;
    check("simple stall s1", 64'(bus1.stall), 64'(0));
    check("simple stall s4", 64'(bus4.stall), 64'(0));
    if (o == 3'd4) m_hi = a;
    if (o == 3'd5) m_lo = a;
    @(negedge clk);
    start = 1'b0; read_req = 1'b0;
    #1;
    check("simple hi s1", 64'(bus1.hi), 64'(m_hi));
    check("simple lo s1", 64'(bus1.lo), 64'(m_lo));
    check("simple busy s1", 64'(bus1.busy), 64'(0));
    check("simple done s1", 64'(bus1.done), 64'(0));
    check("simple hi s4", 64'(bus4.hi), 64'(m_hi));
    check("simple lo s4", 64'(bus4.lo), 64'(m_lo));
    check("simple busy s4", 64'(bus4.busy), 64'(0));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'(1);
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; ce = 1'b0; start = 1'b0; read_req = 1'b0;
    op = '0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset hi s1", 64'(bus1.hi), 64'(0));
    check("reset lo s1", 64'(bus1.lo), 64'(0));
    check("reset busy s1", 64'(bus1.busy), 64'(0));
    check("reset done s1", 64'(bus1.done), 64'(0));
    check("reset hi s4", 64'(bus4.hi), 64'(0));
    check("reset lo s4", 64'(bus4.lo), 64'(0));
    reset = 1'b1; ce = 1'b1;

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, -1);
    check("multu max hi", 64'(bus1.hi), 64'(32'hFFFF_FFFE));
    check("multu max lo", 64'(bus1.lo), 64'(32'h0000_0001));
    run_op(3'd0, -32'sd7, 32'd3, 1'b0, 1'b0, -1);
    check("mult -7x3 lo", 64'(bus4.lo), 64'(32'hFFFF_FFEB));
    run_op(3'd2, -32'sd7, 32'd2, 1'b0, 1'b1, -1);
    check("div -7/2 lo", 64'(bus1.lo), 64'(32'hFFFF_FFFD));
    check("div -7/2 hi", 64'(bus1.hi), 64'(32'hFFFF_FFFF));
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, -1);
    run_op(3'd3, 32'd100, 32'd0, 1'b1, 1'b0, -1);
    check("divu 100/0 lo", 64'(bus1.lo), 64'(32'hFFFF_FFFF));

    // MTLO then MTHI in consecutive idle cycles.
    @(negedge clk);
    start = 1'b1; op = 3'd5; op_a = 32'h1234; read_req = 1'b1;
    #1;
    check("mtlo stall", 64'(bus1.stall), 64'(0));
    @(negedge clk);
    op = 3'd4; op_a = 32'hABCD;
    #1;
    check("mtlo lo s1", 64'(bus1.lo), 64'(32'h1234));
    check("mtlo lo s4", 64'(bus4.lo), 64'(32'h1234));
    check("mthi stall", 64'(bus1.stall), 64'(0));
    @(negedge clk);
    start = 1'b0; read_req = 1'b0;
    #1;
    check("mthi hi s1", 64'(bus1.hi), 64'(32'hABCD));
    check("mthi lo s1", 64'(bus1.lo), 64'(32'h1234));
    check("mthi busy s1", 64'(bus1.busy), 64'(0));
    check("mthi hi s4", 64'(bus4.hi), 64'(32'hABCD));
    m_hi = 32'hABCD; m_lo = 32'h1234;

    run_op(3'd1, $urandom, $urandom, 1'b0, 1'b0, 3);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, -1);
    check("mult min*min hi", 64'(bus1.hi), 64'(32'h4000_0000));

    // Reset in the middle of a DIVU discards it.
    @(negedge clk);
    start = 1'b1; op = 3'd3; op_a = $urandom; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    check("mid divu busy", 64'(bus1.busy), 64'(1));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rst busy s1", 64'(bus1.busy), 64'(0));
      check("rst done s1", 64'(bus1.done), 64'(0));
      check("rst hi s1", 64'(bus1.hi), 64'(0));
      check("rst lo s1", 64'(bus1.lo), 64'(0));
      check("rst done s4", 64'(bus4.done), 64'(0));
      @(negedge clk);
    end

    for (int n = 0; n < 24; n++) begin
      logic [2:0]   o;
      logic [W-1:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      if (o <= 3'd3)
        run_op(o, a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : -1);
      else
        simple_op(o, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
